beam_split_counter: RTL and testbench

Streaming beam-propagation engine for the splitter-grid puzzle, generalising the fixed 142×160, 32-bit-chunk, split-count-only datapath to arbitrary grid geometry and chunk width. It assembles each grid row from chunks, propagates beam occupancy and per-column path counts row by row, and reports both the total split count and the total timeline (path) count. It sits directly behind the memory-streaming front end and replaces the previous top-level counter.

---
 rtl/beam_pkg.sv | 34 +++
 rtl/beam_row_step.sv | 61 ++++++
 rtl/beam_split_counter.sv | 158 +++++++++++++++
 tb/tb_beam_split_counter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/beam_pkg.sv
// Shared types and geometry helpers for the splitter-grid beam engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package beam_pkg;

    // Top-level controller states: stream rows in, sum per-column path
    // counts, then hold the final results.
    typedef enum logic [1:0] {
        STREAM = 2'd0,
        SUM    = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Default geometry of the original fixed-size datapath.
    localparam int DEF_ROWS      = 142;
    localparam int DEF_ROW_WIDTH = 160;
    localparam int DEF_CHUNK_W   = 32;

    // Number of input beats that make up one grid row.
    function automatic int chunks_of(input int row_width, input int chunk_w);
        return row_width / chunk_w;
    endfunction

    // Column c lives at row bit row_width-1-c (column 0 is the row MSB).
    function automatic int col_bit(input int row_width, input int c);
        return row_width - 1 - c;
    endfunction

    // A row must be an exact whole number of chunks.
    function automatic bit width_ok(input int row_width, input int chunk_w);
        return (chunk_w > 0) && (row_width >= chunk_w) && ((row_width % chunk_w) == 0);
    endfunction

endpackage

// File: rtl/beam_row_step.sv
// One splitter-row propagation step: per-column path counts, beam mask, split popcount.
// Latency: purely combinational.
// Backpressure: none (no handshake).
//
// Ports (all vectors indexed by column, bit c = column c):
//   beam     current beam occupancy
//   spl      splitter bits of the row being applied
//   cnt      current per-column path counts
//   new_cnt  path counts below this row
//   beam_nxt occupancy below this row (column has a nonzero count)
//   splits   number of splitters struck by a beam in this row
import beam_pkg::*;

module beam_row_step #(
    parameter int W     = DEF_ROW_WIDTH,
    parameter int TL_W  = 64,
    parameter int CNT_W = 16
) (
    input  logic [W-1:0]     beam,
    input  logic [W-1:0]     spl,
    input  logic [TL_W-1:0]  cnt [W],
    output logic [TL_W-1:0]  new_cnt [W],
    output logic [W-1:0]     beam_nxt,
    output logic [CNT_W-1:0] splits
);

    for (genvar c = 0; c < W; c++) begin : g_col
        logic [TL_W-1:0] from_l;
        logic [TL_W-1:0] from_r;
        logic [TL_W-1:0] stay;

        // Edge columns have no neighbour on one side, so a split there
        // simply loses that branch.
        if (c > 0) begin : g_l
            assign from_l = spl[c-1] ? cnt[c-1] : '0;
        end else begin : g_l0
            assign from_l = '0;
        end

        if (c < W - 1) begin : g_r
            assign from_r = spl[c+1] ? cnt[c+1] : '0;
        end else begin : g_r0
            assign from_r = '0;
        end

        assign stay        = spl[c] ? '0 : cnt[c];
        assign new_cnt[c]  = stay + from_l + from_r;
        assign beam_nxt[c] = |new_cnt[c];
    end

    logic [W-1:0] hit;
    assign hit = beam & spl;

    always_comb begin
        splits = '0;
        for (int c = 0; c < W; c++) begin
            splits = splits + CNT_W'(hit[c]);
        end
    end

endmodule

// File: rtl/beam_split_counter.sv
// Streams grid rows in chunks, propagates beams/path counts, reports splits and timelines.
// Latency: split_count 1 cycle after a row's last chunk; done ROW_WIDTH cycles after the final row.
// Backpressure: none; beats arriving while summing or finished are dropped.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   enable, data    chunk beat (valid + CHUNK_W bits, lowest column at MSB)
//   split_count     running total of splits
//   timeline_count  total path count, valid while done
//   busy            summing per-column counts
//   done            results final, sticky until reset
import beam_pkg::*;

module beam_split_counter #(
    parameter int ROWS      = DEF_ROWS,
    parameter int ROW_WIDTH = DEF_ROW_WIDTH,
    parameter int CHUNK_W   = DEF_CHUNK_W,
    parameter int CNT_W     = 16,
    parameter int TL_W      = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [CHUNK_W-1:0] data,
    output logic [CNT_W-1:0]   split_count,
    output logic [TL_W-1:0]    timeline_count,
    output logic               busy,
    output logic               done
);

    localparam int CHUNKS = chunks_of(ROW_WIDTH, CHUNK_W);
    localparam int CK_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int RI_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W  = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
    // Earlier chunks of the current row; the newest chunk comes straight
    // from the data port so the row can be processed on its last beat.
    localparam int ASM_W  = (CHUNKS > 1) ? ROW_WIDTH - CHUNK_W : 1;

    if (!width_ok(ROW_WIDTH, CHUNK_W)) begin : g_bad_geometry
        $error("beam_split_counter: ROW_WIDTH must be a multiple of CHUNK_W");
    end

    state_e            state_q, state_d;
    logic [CK_W-1:0]   chunk_q;
    logic [RI_W-1:0]   row_q;
    logic [COL_W-1:0]  col_q;
    logic [ASM_W-1:0]  asm_q;
    logic [ROW_WIDTH-1:0] beam_q;
    logic [TL_W-1:0]   cnt_q [ROW_WIDTH];
    logic [TL_W-1:0]   acc_q;
    logic [CNT_W-1:0]  split_q;
    logic [TL_W-1:0]   tl_q;

    logic [ROW_WIDTH-1:0] full_row;
    logic [ROW_WIDTH-1:0] spl_col;
    logic [TL_W-1:0]      step_cnt [ROW_WIDTH];
    logic [ROW_WIDTH-1:0] step_beam;
    logic [CNT_W-1:0]     step_splits;

    logic accept, last_chunk, last_row, last_col;

    assign accept     = enable && (state_q == STREAM);
    assign last_chunk = (chunk_q == CK_W'(CHUNKS - 1));
    assign last_row   = (row_q == RI_W'(ROWS - 1));
    assign last_col   = (col_q == COL_W'(ROW_WIDTH - 1));

    // Chunks shift in from the bottom, so the first chunk of a row ends up
    // in the row MSBs, which is where the lowest columns belong.
    if (CHUNKS > 1) begin : g_multi
        assign full_row = {asm_q, data};
    end else begin : g_single
        assign full_row = data;
    end

    // Re-index the row by column so the step logic works in column space.
    for (genvar c = 0; c < ROW_WIDTH; c++) begin : g_map
        assign spl_col[c] = full_row[col_bit(ROW_WIDTH, c)];
    end

    beam_row_step #(
        .W     (ROW_WIDTH),
        .TL_W  (TL_W),
        .CNT_W (CNT_W)
    ) u_step (
        .beam     (beam_q),
        .spl      (spl_col),
        .cnt      (cnt_q),
        .new_cnt  (step_cnt),
        .beam_nxt (step_beam),
        .splits   (step_splits)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            STREAM:  if (accept && last_chunk && last_row) state_d = SUM;
            SUM:     if (last_col) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = STREAM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STREAM;
            chunk_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            asm_q   <= '0;
            beam_q  <= '0;
            acc_q   <= '0;
            split_q <= '0;
            tl_q    <= '0;
            for (int c = 0; c < ROW_WIDTH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;

            if (accept) begin
                asm_q   <= full_row[ASM_W-1:0];
                chunk_q <= last_chunk ? '0 : chunk_q + 1'b1;
                if (last_chunk) begin
                    row_q <= last_row ? '0 : row_q + 1'b1;
                    if (row_q == '0) begin
                        // Source row: every set bit launches one path.
                        beam_q <= spl_col;
                        for (int c = 0; c < ROW_WIDTH; c++) begin
                            cnt_q[c] <= TL_W'(spl_col[c]);
                        end
                    end else begin
                        beam_q  <= step_beam;
                        cnt_q   <= step_cnt;
                        split_q <= split_q + step_splits;
                    end
                    if (last_row) begin
                        acc_q <= '0;
                        col_q <= '0;
                    end
                end
            end

            if (state_q == SUM) begin
                acc_q <= acc_q + cnt_q[col_q];
                col_q <= col_q + 1'b1;
                if (last_col) begin
                    tl_q <= acc_q + cnt_q[col_q];
                end
            end
        end
    end

    assign split_count    = split_q;
    assign timeline_count = tl_q;
    assign busy           = (state_q == SUM);
    assign done           = (state_q == DONE);

endmodule

// File: tb/tb_beam_split_counter.sv
module tb_beam_split_counter;

    typedef bit grid_t [16][16];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: ROWS=4, ROW_WIDTH=8, CHUNK_W=4
    logic        rst_a, en_a;
    logic [3:0]  dat_a;
    logic [15:0] sc_a;
    logic [63:0] tl_a;
    logic        busy_a, done_a;

    // Instance B: ROWS=5, ROW_WIDTH=16, CHUNK_W=8, TL_W=4 (wrap)
    logic        rst_b, en_b;
    logic [7:0]  dat_b;
    logic [15:0] sc_b;
    logic [3:0]  tl_b;
    logic        busy_b, done_b;

    beam_split_counter #(.ROWS(4), .ROW_WIDTH(8), .CHUNK_W(4), .CNT_W(16), .TL_W(64)) dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .data(dat_a),
        .split_count(sc_a), .timeline_count(tl_a), .busy(busy_a), .done(done_a)
    );

    beam_split_counter #(.ROWS(5), .ROW_WIDTH(16), .CHUNK_W(8), .CNT_W(16), .TL_W(4)) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .data(dat_b),
        .split_count(sc_b), .timeline_count(tl_b), .busy(busy_b), .done(done_b)
    );

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        ntests++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // ---------------- model: timelines as enumerated choice sequences ----
    // A timeline is a source plus one left/right choice per splitter met.
    // Enumerate every choice mask; masks that choose at a non-splitter are
    // duplicates and are skipped; paths leaving the grid are lost.
    function automatic longint timelines(input grid_t g, input int nr, input int nc);
        longint n = 0;
        for (int s = 0; s < nc; s++) begin
            if (g[0][s]) begin
                for (int m = 0; m < (1 << (nr - 1)); m++) begin
                    int  c  = s;
                    bit  ok = 1'b1;
                    for (int r = 1; r < nr && ok; r++) begin
                        bit d = ((m >> (r - 1)) & 1) != 0;
                        if (g[r][c]) begin
                            c = d ? c + 1 : c - 1;
                            if (c < 0 || c >= nc) ok = 1'b0;
                        end else if (d) begin
                            ok = 1'b0;
                        end
                    end
                    if (ok) n++;
                end
            end
        end
        return n;
    endfunction

    // Splitters reached by any beam in rows 1..last_r.
    function automatic int splits_upto(input grid_t g, input int nc, input int last_r);
        bit on [16];
        bit nx [16];
        int n = 0;
        for (int c = 0; c < 16; c++) on[c] = g[0][c];
        for (int r = 1; r <= last_r; r++) begin
            for (int c = 0; c < 16; c++) nx[c] = 1'b0;
            for (int c = 0; c < nc; c++) begin
                if (on[c]) begin
                    if (g[r][c]) begin
                        n++;
                        if (c > 0)      nx[c-1] = 1'b1;
                        if (c < nc - 1) nx[c+1] = 1'b1;
                    end else begin
                        nx[c] = 1'b1;
                    end
                end
            end
            on = nx;
        end
        return n;
    endfunction

    // ---------------- model of instance A, cycle by cycle ----------------
    grid_t       ga;
    grid_t       gb;
    int          mk = 0, mr = 0, ph = 0, left = 0;
    int          e_split = 0;
    logic [63:0] e_tl = '0;
    logic        e_busy = 1'b0, e_done = 1'b0;
    bit          chk_a = 1'b0;

    always @(posedge clk) begin
        if (rst_a) begin
            mk = 0; mr = 0; ph = 0; left = 0;
            e_split = 0; e_tl = '0; e_busy = 1'b0; e_done = 1'b0;
            ga = '{default: '0};
        end else if (ph == 0) begin
            if (en_a) begin
                for (int j = 0; j < 4; j++) ga[mr][mk*4 + j] = dat_a[3 - j];
                if (mk == 1) begin
                    mk = 0;
                    if (mr > 0) e_split = splits_upto(ga, 8, mr) & 16'hFFFF;
                    if (mr == 3) begin
                        ph = 1; left = 8; e_busy = 1'b1;
                    end else begin
                        mr++;
                    end
                end else begin
                    mk++;
                end
            end
        end else if (ph == 1) begin
            left--;
            if (left == 0) begin
                ph = 2; e_busy = 1'b0; e_done = 1'b1;
                e_tl = 64'(timelines(ga, 4, 8));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_a) begin
            chk("a split_count", 64'(sc_a), 64'(e_split));
            chk("a busy", 64'(busy_a), 64'(e_busy));
            chk("a done", 64'(done_a), 64'(e_done));
            chk("a timeline_count", tl_a, e_tl);
        end
    end

    // ---------------- drivers ----------------
    task automatic beat_a(input bit en, input logic [3:0] d);
        en_a = en; dat_a = d;
        @(posedge clk); #1;
    endtask

    task automatic beat_b(input bit en, input logic [7:0] d);
        en_b = en; dat_b = d;
        @(posedge clk); #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        repeat (2) beat_a(1'b0, 4'h0);
        rst_a = 1'b0;
    endtask

    task automatic send_a(input logic [3:0] ch [8], input int gap,
                          input int want_r1, input int want_r2);
        for (int i = 0; i < 8; i++) begin
            beat_a(1'b1, ch[i]);
            if (i == 3) chk("row1 split_count", 64'(sc_a), 64'(want_r1));
            if (i == 5) chk("row2 split_count", 64'(sc_a), 64'(want_r2));
            if (i != 7) for (int k = 0; k < gap; k++) beat_a(1'b0, 4'hF);
        end
        en_a = 1'b0;
    endtask

    task automatic wait_done_a(output int n);
        n = 0;
        while (!done_a && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    logic [3:0] basic [8] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h2, 4'h8, 4'h0, 4'h0};
    logic [3:0] edgev [8] = '{4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [7:0] tree  [10] = '{8'h00, 8'h80, 8'h00, 8'h80, 8'h01, 8'h40,
                               8'h02, 8'hA0, 8'h05, 8'h50};

    initial begin
        int n, c0;
        rst_a = 1'b1; en_a = 1'b0; dat_a = '0;
        rst_b = 1'b1; en_b = 1'b0; dat_b = '0;
        gb = '{default: '0};
        repeat (2) beat_a(1'b0, 4'h0);
        rst_a = 1'b0;
        chk_a = 1'b1;
        chk("reset split_count", 64'(sc_a), 64'd0);
        chk("reset timeline_count", tl_a, 64'd0);
        chk("reset busy", 64'(busy_a), 64'd0);
        chk("reset done", 64'(done_a), 64'd0);

        // Basic
        c0 = cyc;
        send_a(basic, 0, 1, 3);
        chk("basic busy after last beat", 64'(busy_a), 64'd1);
        wait_done_a(n);
        chk("basic done latency", 64'(n), 64'd8);
        chk("basic total cycles", 64'(cyc - c0), 64'd16);
        chk("basic split_count", 64'(sc_a), 64'd3);
        chk("basic timeline_count", tl_a, 64'd4);
        chk("model basic timelines", 64'(timelines(ga, 4, 8)), 64'd4);

        // Edge drop
        reset_a();
        send_a(edgev, 0, 1, 1);
        wait_done_a(n);
        chk("edge split_count", 64'(sc_a), 64'd1);
        chk("edge timeline_count", tl_a, 64'd1);
        chk("model edge timelines", 64'(timelines(ga, 4, 8)), 64'd1);

        // Stalls
        reset_a();
        c0 = cyc;
        send_a(basic, 3, 1, 3);
        wait_done_a(n);
        chk("stall done latency", 64'(n), 64'd8);
        chk("stall total cycles", 64'(cyc - c0), 64'd37);
        chk("stall split_count", 64'(sc_a), 64'd3);
        chk("stall timeline_count", tl_a, 64'd4);

        // Ignored input through SUM and DONE
        reset_a();
        send_a(basic, 0, 1, 3);
        for (int i = 0; i < 30; i++) beat_a(1'b1, (i % 2) ? 4'hA : 4'h5);
        en_a = 1'b0;
        chk("ignored split_count", 64'(sc_a), 64'd3);
        chk("ignored timeline_count", tl_a, 64'd4);
        chk("ignored done", 64'(done_a), 64'd1);

        // Reset in the middle of row 2
        reset_a();
        for (int i = 0; i < 5; i++) beat_a(1'b1, basic[i]);
        chk("midrow split before reset", 64'(sc_a), 64'd1);
        rst_a = 1'b1;
        beat_a(1'b1, 4'hF);
        chk("midrow reset split_count", 64'(sc_a), 64'd0);
        chk("midrow reset busy", 64'(busy_a), 64'd0);
        beat_a(1'b1, 4'hF);
        rst_a = 1'b0;
        en_a = 1'b0;
        send_a(basic, 0, 1, 3);
        wait_done_a(n);
        chk("midrow split_count", 64'(sc_a), 64'd3);
        chk("midrow timeline_count", tl_a, 64'd4);

        // Wrap: 16-wide binary tree of depth 4 on a 4-bit timeline counter
        rst_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 8; j++) gb[i/2][(i%2)*8 + j] = tree[i][7 - j];
            beat_b(1'b1, tree[i]);
        end
        en_b = 1'b0;
        chk("wrap busy after last beat", 64'(busy_b), 64'd1);
        n = 0;
        while (!done_b && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wrap done latency", 64'(n), 64'd16);
        chk("model wrap timelines", 64'(timelines(gb, 5, 16)), 64'd16);
        chk("model wrap splits", 64'(splits_upto(gb, 16, 4)), 64'd10);
        chk("wrap split_count", 64'(sc_b), 64'(splits_upto(gb, 16, 4)));
        chk("wrap timeline_count", 64'(tl_b), 64'(timelines(gb, 5, 16) & 15));
        chk("wrap timeline literal", 64'(tl_b), 64'd0);
        chk("wrap done", 64'(done_b), 64'd1);

        chk_a = 1'b0;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
